// File: rtl/apb_master_ctrl.sv
// APB master: one request at a time, IDLE/SETUP/ACCESS sequencing, decode-error handling.
// Define APB_MASTER_TIMEOUT_EN to abort transfers stalled for TIMEOUT_CYCLES wait states.
`timescale 1ns/1ps
module apb_master_ctrl #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic                             REQ_VALID,
  output logic                             REQ_READY,
  input  logic                             REQ_WRITE,
  input  logic [ADDRESS_WIDTH-1:0]         REQ_ADDR,
  input  logic [DATA_WIDTH-1:0]            REQ_WDATA,
  input  logic [DATA_WIDTH/8-1:0]          REQ_STRB,
  output logic                             RSP_VALID,
  output logic [DATA_WIDTH-1:0]            RSP_RDATA,
  output logic                             RSP_ERR,
  output logic                             RSP_TIMEOUT,
  output logic [ADDRESS_WIDTH-1:0]         M_PADDR,
  output logic [DATA_WIDTH-1:0]            M_PWDATA,
  output logic [DATA_WIDTH/8-1:0]          M_PSTRB,
  output logic                             M_PWRITE,
  output logic [NUM_SLAVES-1:0]            M_PSEL,
  output logic                             M_PENABLE,
  input  logic [NUM_SLAVES-1:0]            M_PREADY,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] M_PRDATA,
  input  logic [NUM_SLAVES-1:0]            M_PSLVERR
);

  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int SB = DATA_WIDTH / 8;
  localparam logic [SW:0] NS = (SW+1)'(NUM_SLAVES);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]               state;
  logic                     wr_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [SB-1:0]            strb_q;
  logic [SW-1:0]            idx_q;
  logic                     derr_q;

  logic [SW-1:0]            idx_d;
  logic                     sel_ready;
  logic                     sel_err;
  logic [DATA_WIDTH-1:0]    sel_rdata;
  logic                     tmo;
  logic                     done;
  logic                     accept;
  logic                     busy;

  assign idx_d = REQ_ADDR[SEL_LSB +: SW];

  // A decode error behaves like a ready slave so ACCESS ends at once.
  always_comb begin
    sel_ready = derr_q;
    sel_err   = derr_q;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!derr_q && idx_q == SW'(i)) begin
        sel_ready = M_PREADY[i];
        sel_err   = M_PSLVERR[i];
        sel_rdata = M_PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wcnt;

  assign tmo = (state == ACCESS) && !sel_ready &&
               (wcnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wcnt <= '0;
    end else if (state == ACCESS && !sel_ready && !tmo) begin
      wcnt <= wcnt + 1'b1;
    end else begin
      wcnt <= '0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) RSP_TIMEOUT <= 1'b0;
    else        RSP_TIMEOUT <= tmo;
  end
`else
  assign tmo         = 1'b0;
  assign RSP_TIMEOUT = 1'b0;
`endif

  assign done      = (state == ACCESS) && (sel_ready || tmo);
  assign REQ_READY = !PRESET && ((state == IDLE) || done);
  assign accept    = REQ_VALID && REQ_READY;
  assign busy      = (state != IDLE);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state <= SETUP;
        SETUP:   state <= ACCESS;
        ACCESS:  if (done) state <= accept ? SETUP : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write-only fields are zeroed at capture so reads present 0 on the bus.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      idx_q   <= '0;
      derr_q  <= 1'b0;
    end else if (accept) begin
      wr_q    <= REQ_WRITE;
      addr_q  <= REQ_ADDR;
      wdata_q <= REQ_WRITE ? REQ_WDATA : '0;
      strb_q  <= REQ_WRITE ? REQ_STRB : '0;
      idx_q   <= idx_d;
      derr_q  <= ({1'b0, idx_d} >= NS);
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      RSP_VALID <= 1'b0;
      RSP_ERR   <= 1'b0;
      RSP_RDATA <= '0;
    end else begin
      RSP_VALID <= done;
      RSP_ERR   <= done && (sel_err || tmo);
      RSP_RDATA <= (done && !wr_q && !tmo) ? sel_rdata : '0;
    end
  end

  always_comb begin
    M_PSEL = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (busy && !derr_q && idx_q == SW'(i)) M_PSEL[i] = 1'b1;
    end
  end

  assign M_PENABLE = (state == ACCESS);
  assign M_PADDR   = busy ? addr_q  : '0;
  assign M_PWRITE  = busy ? wr_q    : 1'b0;
  assign M_PWDATA  = busy ? wdata_q : '0;
  assign M_PSTRB   = busy ? strb_q  : '0;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: directed and random transfers against a
// transaction-level timeline model, plus a 3-slave instance for decode errors.
`timescale 1ns/1ps
module tb_apb_master_ctrl;

  localparam int TO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    bit          err;
    logic [31:0] rdata;
  } txn_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_write = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [31:0]  req_wdata = '0;
  logic [3:0]   req_strb = '0;
  logic         req_ready;
  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic         rsp_to;
  logic [31:0]  paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic         pwrite;
  logic [3:0]   psel;
  logic         penable;
  logic [3:0]   pready = '0;
  logic [127:0] prdata = '0;
  logic [3:0]   pslverr = '0;

  logic         v3 = 1'b0;
  logic         req_ready3;
  logic         rsp_valid3;
  logic [31:0]  rsp_rdata3;
  logic         rsp_err3;
  logic         rsp_to3;
  logic [31:0]  paddr3;
  logic [31:0]  pwdata3;
  logic [3:0]   pstrb3;
  logic         pwrite3;
  logic [2:0]   psel3;
  logic         penable3;
  logic [2:0]   pready3 = '0;
  logic [95:0]  prdata3 = '0;
  logic [2:0]   pslverr3 = '0;

  int checks = 0;
  int failures = 0;

  bit          pend = 1'b0;
  logic [31:0] p_rdata;
  bit          p_err;
  bit          p_to;

  always #5 clk = ~clk;

  apb_master_ctrl #(.NUM_SLAVES(4), .TIMEOUT_CYCLES(TO)) u_dut (
    .PCLK(clk), .PRESET(rst),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WRITE(req_write),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .REQ_STRB(req_strb),
    .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
    .RSP_TIMEOUT(rsp_to),
    .M_PADDR(paddr), .M_PWDATA(pwdata), .M_PSTRB(pstrb), .M_PWRITE(pwrite),
    .M_PSEL(psel), .M_PENABLE(penable),
    .M_PREADY(pready), .M_PRDATA(prdata), .M_PSLVERR(pslverr)
  );

  apb_master_ctrl #(.NUM_SLAVES(3)) u_dut3 (
    .PCLK(clk), .PRESET(rst),
    .REQ_VALID(v3), .REQ_READY(req_ready3), .REQ_WRITE(req_write),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .REQ_STRB(req_strb),
    .RSP_VALID(rsp_valid3), .RSP_RDATA(rsp_rdata3), .RSP_ERR(rsp_err3),
    .RSP_TIMEOUT(rsp_to3),
    .M_PADDR(paddr3), .M_PWDATA(pwdata3), .M_PSTRB(pstrb3), .M_PWRITE(pwrite3),
    .M_PSEL(psel3), .M_PENABLE(penable3),
    .M_PREADY(pready3), .M_PRDATA(prdata3), .M_PSLVERR(pslverr3)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Random slave bus, with the selected slave's fields overridden.
  task automatic slv(input int idx, input bit rdy, input bit err,
                     input logic [31:0] rd);
    pready  = 4'($urandom);
    pslverr = 4'($urandom);
    for (int j = 0; j < 4; j++) prdata[j*32 +: 32] = $urandom;
    pready[idx] = rdy;
    if (rdy) begin
      pslverr[idx] = err;
      prdata[idx*32 +: 32] = rd;
    end
  endtask

  function automatic txn_t rnd_txn();
    txn_t t;
    t.wr    = 1'($urandom);
    t.addr  = $urandom;
    t.wdata = $urandom;
    t.strb  = 4'($urandom);
    t.waits = $urandom_range(0, 3);
    t.err   = ($urandom_range(0, 3) == 0);
    t.rdata = $urandom;
    return t;
  endfunction

  task automatic put_req(input txn_t t);
    req_valid = 1'b1;
    req_write = t.wr;
    req_addr  = t.addr;
    req_wdata = t.wdata;
    req_strb  = t.strb;
  endtask

  // One transfer as a timeline: SETUP, acc ACCESS cycles, then response.
  task automatic xfer(input txn_t t, input bit cin, input bit cout,
                      input txn_t n);
    int          idx;
    int          acc;
    bit          timed;
    bit          last;
    bit          rdy;
    logic [3:0]  e_sel;
    logic [31:0] e_wd;
    logic [3:0]  e_st;
    idx   = int'(t.addr[13:12]);
    timed = TMO_EN && (t.waits >= TO);
    acc   = timed ? TO : t.waits + 1;
    e_sel = 4'b0001 << idx;
    e_wd  = t.wr ? t.wdata : 32'h0;
    e_st  = t.wr ? t.strb : 4'h0;
    if (!cin) begin
      @(negedge clk);
      put_req(t);
      slv(idx, 1'($urandom), 1'b0, 32'h0);
      #1;
      chk("idle_ready", req_ready, 1'b1);
      chk("rsp_pulse_end", rsp_valid, 1'b0);
      @(posedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    slv(idx, 1'($urandom), 1'($urandom), $urandom);
    #1;
    chk("setup_psel", psel, e_sel);
    chk("setup_penable", penable, 1'b0);
    chk("setup_paddr", paddr, t.addr);
    chk("setup_pwrite", pwrite, t.wr);
    chk("setup_pwdata", pwdata, e_wd);
    chk("setup_pstrb", pstrb, e_st);
    chk("setup_ready", req_ready, 1'b0);
    chk("setup_rsp_valid", rsp_valid, pend);
    if (pend) begin
      chk("b2b_rsp_rdata", rsp_rdata, p_rdata);
      chk("b2b_rsp_err", rsp_err, p_err);
      chk("b2b_rsp_to", rsp_to, p_to);
    end
    pend = 1'b0;
    @(posedge clk);
    for (int k = 0; k < acc; k++) begin
      @(negedge clk);
      last = (k == acc - 1);
      rdy  = (k == t.waits);
      slv(idx, rdy, t.err, t.rdata);
      if (last && cout) put_req(n);
      #1;
      chk("acc_psel", psel, e_sel);
      chk("acc_penable", penable, 1'b1);
      chk("acc_paddr", paddr, t.addr);
      chk("acc_pwdata", pwdata, e_wd);
      chk("acc_pstrb", pstrb, e_st);
      chk("acc_ready", req_ready, last);
      chk("acc_rsp_valid", rsp_valid, 1'b0);
      @(posedge clk);
    end
    pend    = 1'b1;
    p_rdata = (t.wr || timed) ? 32'h0 : t.rdata;
    p_err   = timed || t.err;
    p_to    = timed;
    if (!cout) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk("rsp_valid", rsp_valid, 1'b1);
      chk("rsp_rdata", rsp_rdata, p_rdata);
      chk("rsp_err", rsp_err, p_err);
      chk("rsp_timeout", rsp_to, p_to);
      chk("idle_psel", psel, 4'h0);
      chk("idle_penable", penable, 1'b0);
      chk("idle_paddr", paddr, 32'h0);
      chk("idle_pwrite", pwrite, 1'b0);
      chk("idle_ready_after", req_ready, 1'b1);
      pend = 1'b0;
    end
  endtask

  initial begin
    txn_t a;
    txn_t b;
    txn_t cur;
    txn_t nxt;
    bit   chained;
    bit   c;

    #3;
    chk("rst_psel", psel, 4'h0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_to", rsp_to, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    a = '{wr: 1'b1, addr: 32'h0000_2010, wdata: 32'hDEAD_BEEF,
          strb: 4'hF, waits: 0, err: 1'b0, rdata: 32'h0};
    xfer(a, 1'b0, 1'b0, a);

    a = '{wr: 1'b0, addr: 32'h0000_1004, wdata: 32'hFFFF_FFFF,
          strb: 4'hF, waits: 2, err: 1'b0, rdata: 32'h1234_5678};
    xfer(a, 1'b0, 1'b0, a);

    a = '{wr: 1'b1, addr: 32'h0000_3020, wdata: 32'hA5A5_0001,
          strb: 4'h3, waits: 1, err: 1'b0, rdata: 32'h0};
    b = '{wr: 1'b0, addr: 32'h0000_0040, wdata: 32'h0,
          strb: 4'h0, waits: 0, err: 1'b1, rdata: 32'hCAFE_F00D};
    xfer(a, 1'b0, 1'b1, b);
    xfer(b, 1'b1, 1'b0, b);

    a = '{wr: 1'b0, addr: 32'h0000_2000, wdata: 32'h0,
          strb: 4'h0, waits: 6, err: 1'b0, rdata: 32'h7777_0000};
    xfer(a, 1'b0, 1'b0, a);

    cur = rnd_txn();
    chained = 1'b0;
    for (int i = 0; i < 24; i++) begin
      nxt = rnd_txn();
      c = 1'($urandom);
      xfer(cur, chained, c, nxt);
      chained = c;
      cur = nxt;
    end
    if (chained) xfer(cur, 1'b1, 1'b0, cur);

    // Reset during the second ACCESS cycle of a waited read.
    @(negedge clk);
    a = '{wr: 1'b0, addr: 32'h0000_3000, wdata: 32'h0,
          strb: 4'h0, waits: 3, err: 1'b0, rdata: 32'h0};
    put_req(a);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    slv(3, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    slv(3, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    slv(3, 1'b0, 1'b0, 32'h0);
    #1;
    chk("pre_rst_penable", penable, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_psel", psel, 4'h0);
    chk("arst_penable", penable, 1'b0);
    chk("arst_ready", req_ready, 1'b0);
    chk("arst_rsp_valid", rsp_valid, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("post_rst_no_rsp", rsp_valid, 1'b0);
      chk("post_rst_psel", psel, 4'h0);
      chk("post_rst_ready", req_ready, 1'b1);
      @(negedge clk);
    end
    a = '{wr: 1'b0, addr: 32'h0000_3008, wdata: 32'h0,
          strb: 4'h0, waits: 1, err: 1'b0, rdata: 32'h0BAD_CAFE};
    xfer(a, 1'b0, 1'b0, a);

    // Three-slave instance: index 3 decodes to nothing.
    @(negedge clk);
    v3 = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0000_3010;
    pready3   = 3'b000;
    prdata3   = {$urandom, $urandom, $urandom};
    #1;
    chk("dec_idle_ready", req_ready3, 1'b1);
    @(posedge clk);
    @(negedge clk);
    v3 = 1'b0;
    #1;
    chk("dec_setup_psel", psel3, 3'b000);
    chk("dec_setup_penable", penable3, 1'b0);
    @(posedge clk);
    @(negedge clk);
    pslverr3 = 3'b000;
    #1;
    chk("dec_acc_psel", psel3, 3'b000);
    chk("dec_acc_penable", penable3, 1'b1);
    chk("dec_acc_ready", req_ready3, 1'b1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("dec_rsp_valid", rsp_valid3, 1'b1);
    chk("dec_rsp_err", rsp_err3, 1'b1);
    chk("dec_rsp_rdata", rsp_rdata3, 32'h0);

    @(negedge clk);
    v3 = 1'b1;
    req_addr = 32'h0000_2000;
    @(posedge clk);
    @(negedge clk);
    v3 = 1'b0;
    #1;
    chk("s3_setup_psel", psel3, 3'b100);
    @(posedge clk);
    @(negedge clk);
    pready3 = 3'b100;
    pslverr3 = 3'b011;
    prdata3 = {32'h5A5A_1234, 32'h1111_1111, 32'h2222_2222};
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("s3_rsp_valid", rsp_valid3, 1'b1);
    chk("s3_rsp_rdata", rsp_rdata3, 32'h5A5A_1234);
    chk("s3_rsp_err", rsp_err3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
